// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op-code enum and op legality.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
//
// Optional feature macro: SHIFTER_ROTATE_EN (when undefined, ROL/ROR are reserved codes).
package shifter_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } op_e;

    // True for codes that must pass data unshifted and flag an error.
    function automatic logic op_reserved(input logic [OP_W-1:0] op);
        logic res;
        res = 1'b1;
        case (op)
            OP_SLL, OP_SRL, OP_SRA: res = 1'b0;
`ifdef SHIFTER_ROTATE_EN
            OP_ROL, OP_ROR:         res = 1'b0;
`endif
            default:                res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter pipeline stage: conditional shift by DIST positions plus its payload registers.
// Latency: 1 cycle (registered output).
// Backpressure: loads only when adv=1; holds all registers otherwise.
//
// Ports: clk, rst_n (async active-low); adv (this stage advances this cycle);
//   in_vld/in_dat/in_op/in_shamt/in_err from the previous stage (or the block input);
//   out_vld/out_dat/out_op/out_shamt/out_err registered towards the next stage.
// Optional feature macro: SHIFTER_ROTATE_EN (wrap-around paths exist only when defined).
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     adv,
    input  logic                     in_vld,
    input  logic [WIDTH-1:0]         in_dat,
    input  op_e                      in_op,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic                     in_err,
    output logic                     out_vld,
    output logic [WIDTH-1:0]         out_dat,
    output op_e                      out_op,
    output logic [$clog2(WIDTH)-1:0] out_shamt,
    output logic                     out_err
);

    // Shift-amount bit this stage is responsible for.
    localparam int K = $clog2(DIST);

    logic [WIDTH-1:0] shifted;

    // Reserved ops travel with err=1 and are never shifted. SRA takes its fill from
    // the stage input MSB: earlier SRA stages already replicated the original sign there.
    always_comb begin
        shifted = in_dat;
        if (in_shamt[K] && !in_err) begin
            case (in_op)
                OP_SLL:  shifted = in_dat << DIST;
                OP_SRL:  shifted = in_dat >> DIST;
                OP_SRA:  shifted = {{DIST{in_dat[WIDTH-1]}}, in_dat[WIDTH-1:DIST]};
`ifdef SHIFTER_ROTATE_EN
                OP_ROL:  shifted = {in_dat[WIDTH-DIST-1:0], in_dat[WIDTH-1:WIDTH-DIST]};
                OP_ROR:  shifted = {in_dat[DIST-1:0], in_dat[WIDTH-1:DIST]};
`endif
                default: shifted = in_dat;
            endcase
        end
    end

    // Payload only loads alongside a valid so a drained stage keeps its last data;
    // the valid bit alone decides whether anything downstream looks at it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld   <= 1'b0;
            out_dat   <= '0;
            out_op    <= OP_SLL;
            out_shamt <= '0;
            out_err   <= 1'b0;
        end else if (adv) begin
            out_vld <= in_vld;
            if (in_vld) begin
                out_dat   <= shifted;
                out_op    <= in_op;
                out_shamt <= in_shamt;
                out_err   <= in_err;
            end
        end
    end

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROL/ROR), one stage per shift-amount bit.
// Latency: $clog2(WIDTH) cycles from input transfer to out_valid when not stalled.
// Backpressure: per-stage advance chain; empty stages keep moving while the output stalls.
//
// Ports: clk, rst_n (async active-low);
//   in_valid/in_ready/in_data/in_shamt/in_op  - operand handshake;
//   out_valid/out_ready/out_data/out_err      - result handshake (out_err flags reserved ops).
// Optional feature macro: SHIFTER_ROTATE_EN (ROL/ROR supported; otherwise they are reserved).
module pipe_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [2:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_err
);

    localparam int SHW = $clog2(WIDTH);

    // Index 0 is the block input; index k+1 is the register set of stage k.
    logic             stg_vld   [SHW+1];
    logic [WIDTH-1:0] stg_dat   [SHW+1];
    op_e              stg_op    [SHW+1];
    logic [SHW-1:0]   stg_shamt [SHW+1];
    logic             stg_err   [SHW+1];

    logic [SHW-1:0]   adv;

    assign stg_vld[0]   = in_valid;
    assign stg_dat[0]   = in_data;
    assign stg_op[0]    = op_e'(in_op);
    assign stg_shamt[0] = in_shamt;
    assign stg_err[0]   = op_reserved(in_op);

    // A stage advances when it is empty or its successor advances; the chain is
    // evaluated from the output end so a free slot anywhere ripples back to the input.
    always_comb begin
        adv = '0;
        adv[SHW-1] = ~stg_vld[SHW] | out_ready;
        for (int k = SHW - 2; k >= 0; k--) begin
            adv[k] = ~stg_vld[k+1] | adv[k+1];
        end
    end

    assign in_ready = adv[0];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .adv       (adv[k]),
            .in_vld    (stg_vld[k]),
            .in_dat    (stg_dat[k]),
            .in_op     (stg_op[k]),
            .in_shamt  (stg_shamt[k]),
            .in_err    (stg_err[k]),
            .out_vld   (stg_vld[k+1]),
            .out_dat   (stg_dat[k+1]),
            .out_op    (stg_op[k+1]),
            .out_shamt (stg_shamt[k+1]),
            .out_err   (stg_err[k+1])
        );
    end

    // The last stage drives the outputs directly; no extra output register.
    assign out_valid = stg_vld[SHW];
    assign out_data  = stg_dat[SHW];
    assign out_err   = stg_err[SHW];

    // Op and shift amount are not needed past the final stage.
    logic unused_tail;
    assign unused_tail = ^{stg_op[SHW], stg_shamt[SHW]};

endmodule

// File: doc/pipe_barrel_shifter.md
# pipe_barrel_shifter

Parametrised, pipelined barrel shifter for the shifter lab datapath. It takes one operand per cycle over a valid/ready handshake and applies logical-left, logical-right, arithmetic-right or (optionally) rotate operations. The shift is done in log2(WIDTH) registered stages, one per shift-amount bit, with per-stage backpressure. It supersedes the fixed 8-bit combinational mux-tree shifter and feeds the lab's display/LFSR logic through the same handshake.

## Interface

Parameters:
- WIDTH, default 8: data width. Must be a power of two, at least 2.
- SHW, derived as $clog2(WIDTH), not overridable: shift-amount width and pipeline depth.

Ports:
- clk, input, 1: the single clock. All state changes on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: input operand is valid.
- in_ready, output, 1: block accepts an input this cycle.
- in_data, input, WIDTH: operand.
- in_shamt, input, SHW: shift amount, 0..WIDTH-1.
- in_op, input, 3: operation code (see Operation).
- out_valid, output, 1: result is valid.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, WIDTH: result.
- out_err, output, 1: the transaction carried a reserved op code.

## Operation

- Op codes: 000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR. Codes 101–111 are reserved: data passes unshifted and out_err=1.
- Stage k (k = 0..SHW-1) holds: valid, data, op, remaining shamt bits, and err.
  - If shamt[k]=1, the stage applies a shift of 2^k positions in the op's direction. Otherwise it passes data through.
- Fill rules:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: the original operand's sign bit enters at the MSB. The sign comes from the stage input MSB, which is preserved through earlier SRA stages.
  - ROL/ROR: the bits shifted out re-enter at the opposite end.
- The last stage's registers drive out_valid, out_data and out_err directly. There is no extra output register.
- Handshake:
  - A transfer occurs on a cycle with valid && ready, on both sides.
  - Stage k advances when it is empty or stage k+1 advances. The final stage advances when it is empty or out_ready=1.
  - in_ready = stage 0 advances. It is combinational from the stage valids and out_ready. It never depends on in_valid.
  - Bubbles collapse: a stalled output does not block stages that are empty.
- While out_valid=1 and out_ready=0, out_data and out_err hold stable.
- No reordering and no drops. Results leave in input order.

## Timing

- Latency: SHW cycles from input transfer to out_valid, when no stall. For WIDTH=8 this is 3.
- Throughput: one result per cycle with out_ready held at 1.
- Reset values: all stage valids 0, out_valid=0, out_data=0, out_err=0. in_ready=1 from the first cycle after reset deassertion.
- Reset asserted mid-operation discards every in-flight transaction immediately and asynchronously. No partial result is emitted afterwards.
- Full pipeline with out_ready=0: in_ready=0 in the same cycle.
- out_ready rising while the pipeline is full:
  - The output transfers.
  - in_ready=1 in that same cycle.
  - A simultaneous input is accepted.
- in_shamt=0: result equals in_data for every valid op. out_err=0.

## Configuration

- SHIFTER_ROTATE_EN defined: ROL (011) and ROR (100) rotate as specified. out_err=0 for these codes.
- SHIFTER_ROTATE_EN undefined:
  - 011 and 100 become reserved: data passes unshifted, out_err=1.
  - The wrap-around mux paths are not synthesised.

## Structure

- Package shifter_pkg holds the op-code enum: OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR.
- Sub-module shift_stage is parametrised by WIDTH and stage distance DIST = 2^k.
  - It contains the combinational shift and fill for one stage plus its registers.
  - The top instantiates it SHW times in a generate loop and wires the stage-advance chain.

## Test plan

All scenarios use WIDTH=8. SHIFTER_ROTATE_EN is defined unless stated otherwise.
- Basic shifts: in_data=0x96, shamt=3, out_ready=1.
  - SLL gives 0xB0; SRL gives 0x12; SRA gives 0xF2.
  - Each appears exactly 3 cycles after acceptance, with out_err=0.
- Rotates: 0x96, shamt=3.
  - ROL gives 0xB4; ROR gives 0xD2.
  - Rebuilt without the macro: both give 0x96 with out_err=1.
- Reserved op and zero shift:
  - op=111, 0x5A, shamt=5 gives 0x5A with out_err=1.
  - SRA 0x80, shamt=0 gives 0x80.
  - SRA 0x80, shamt=7 gives 0xFF.
- Back-to-back with backpressure:
  - 8 consecutive inputs with out_ready=0.
  - in_ready drops after 3 accepts; out_data is stable while stalled.
  - Releasing out_ready drains all 8 in order, one per cycle.
- Bubble collapse:
  - Drive inputs every other cycle with out_ready=0 until full, then toggle out_ready.
  - No loss and no duplication: the scoreboard matches a reference model.
- Reset mid-flight:
  - Assert rst_n=0 with 3 transactions in flight.
  - out_valid=0 and out_data=0 immediately.
  - After release, no stale result appears and the first new result has latency 3.
